chip8_debug_master: RTL and testbench
=====================================

# chip8_debug_master

Debug-port initiator for `chip8_memory`. It parses a byte-serial command stream from a host link (UART RX framing upstream), issues single-cycle read/write transactions on the memory's debug port, waits out the memory read latency, and returns one response byte per command on a valid/ready TX stream. It sits between the host UART and `chip8_memory`, driving the `debug_*_in` pins that otherwise only the bench drives.

## Interface
- `READ_LATENCY`, default 2: cycles from the `debug_valid` issue cycle to valid `data_out` from `chip8_memory`. Range 1–15.
- `ACK_BYTE`, default 8'hA5: response byte for a completed write.
- `TIMEOUT_CYCLES`, default 1_000_000: idle limit inside a partially received command.

Ports:
- `clk_in` in 1: system clock.
- `rst_n_in` in 1: asynchronous, active-low reset.
- `rx_data_in` in 8: host command byte.
- `rx_valid_in` in 1: one-cycle strobe; `rx_data_in` is valid. There is no backpressure.
- `tx_data_out` out 8: response byte.
- `tx_valid_out` out 1: response valid; held until accepted.
- `tx_ready_in` in 1: TX sink accepts when `tx_valid_out && tx_ready_in`.
- `debug_addr_out` out 12: connects to `chip8_memory.debug_addr_in`.
- `debug_we_out` out 1: connects to `debug_we_in`.
- `debug_valid_out` out 1: connects to `debug_valid_in`.
- `debug_type_out` out 2: connects to `debug_type_in`.
- `debug_wdata_out` out 8: write data.
- `mem_data_in` in 8: connects to `chip8_memory.data_out`.
- `busy_out` out 1: high in every state except HDR.
- `error_out` out 1: one-cycle pulse on a malformed header, a dropped byte, or a timeout.

## Operation
Command framing:
- Header byte: [7] = we, [6:5] = type, [4] = reserved (must be 0), [3:0] = addr[11:8].
- Next byte: addr[7:0].
- Then one data byte, sent only when we = 1.

FSM states: HDR, ADDR, DATA, ISSUE, WAIT, RESP.
- **HDR:** on `rx_valid_in`:
  - If bit 4 = 1, pulse `error_out` and stay in HDR.
  - Otherwise latch we, type and addr[11:8], then go to ADDR.
- **ADDR:** on a byte, latch addr[7:0]. Go to DATA if we = 1, else ISSUE.
- **DATA:** on a byte, latch the write data and go to ISSUE.
- **ISSUE:** assert `debug_valid_out` for exactly this one cycle, with addr, we, type and wdata stable.
  - A write goes to RESP with `tx_data_out` = `ACK_BYTE`.
  - A read goes to WAIT.
- **WAIT:** a 4-bit counter counts `READ_LATENCY` cycles after ISSUE. On the last count, capture `mem_data_in` into the TX register and go to RESP.
- **RESP:** hold `tx_valid_out` = 1 and `tx_data_out` stable until `tx_ready_in`; then return to HDR.

Rules:
- `rx_valid_in` in ISSUE, WAIT or RESP: the byte is dropped and `error_out` pulses. The FSM is unaffected.
- `debug_addr_out`, `debug_type_out` and `debug_wdata_out` hold their last issued values between transactions. `debug_we_out` is 0 whenever `debug_valid_out` is 0.
- Simultaneous `tx_ready_in` and `rx_valid_in` in the accept cycle: the byte is dropped with `error_out`. HDR is entered the following cycle.

## Timing
- Reset values (asynchronous, while `rst_n_in` = 0):
  - State = HDR.
  - `debug_addr_out` = 0, `debug_we_out` = 0, `debug_valid_out` = 0, `debug_type_out` = 0, `debug_wdata_out` = 0.
  - `tx_data_out` = 0, `tx_valid_out` = 0, `busy_out` = 0, `error_out` = 0.
  - Counters = 0.
- Reset asserted mid-command or mid-RESP: the partial command and any pending response are discarded. No debug strobe is issued after release.
- Read latency: the last byte's `rx_valid_in` is at edge N. `debug_valid_out` is high in cycle N+1, and `tx_valid_out` rises at N+2+`READ_LATENCY`.
- Write latency: the data byte is at edge N. ISSUE is in cycle N+1, and `tx_valid_out` rises at N+2.
- All outputs are registered.

## Configuration
- `CHIP8_DEBUG_TIMEOUT_EN` defined:
  - A counter runs in ADDR and DATA and resets on each `rx_valid_in`.
  - On reaching `TIMEOUT_CYCLES`, pulse `error_out`, discard the command and return to HDR.
- `CHIP8_DEBUG_TIMEOUT_EN` undefined:
  - No counter is built.
  - A partial command waits indefinitely; `TIMEOUT_CYCLES` is ignored.

## Test plan
- **Read:** `chip8_memory` loaded with ibm.mem, RX 8'h02, 8'h01 → one `debug_valid_out` pulse with addr 12'h201, we 0, type 0. `tx_data_out` = 8'hE0 at N+2+`READ_LATENCY`.
- **Write then read back:** RX 8'hA0, 8'h05, 8'h3C (we = 1, type 1, addr 12'h005) → response 8'hA5. RX 8'h20, 8'h05 → response 8'h3C.
- **TX backpressure:** hold `tx_ready_in` = 0 for 20 cycles → `tx_valid_out` and `tx_data_out` stay constant and `busy_out` = 1. Release → one accept, then HDR.
- **Malformed input:**
  - RX header 8'h10 → `error_out` pulse and no strobe.
  - RX byte during WAIT → `error_out` pulse; the response byte is still correct.
- **Reset:** assert `rst_n_in` low after the header only → all outputs at their reset values immediately. After release, RX 8'h02, 8'h00 → a clean read of 12'h200 returns 8'h00.
- **Timeout (macro on, `TIMEOUT_CYCLES` = 50):** header only, then idle for 50 cycles → `error_out` pulse, `busy_out` falls, and no `debug_valid_out` occurs.

Source files
------------

// File: rtl/chip8_debug_master.sv
`default_nettype none
// ============================================================================
//  Module   : chip8_debug_master
//  Purpose  : Debug-port initiator for chip8_memory. Parses a byte-serial
//             host command stream, issues one single-cycle read or write on
//             the memory debug port, waits out the memory read latency and
//             returns one response byte per command on a valid/ready stream.
//
//  Command framing:
//             header : [7] we, [6:5] type, [4] reserved (0), [3:0] addr[11:8]
//             byte 2 : addr[7:0]
//             byte 3 : write data (only when we = 1)
//
//  Ports    : clk_in / rst_n_in   clock, asynchronous active-low reset
//             rx_data_in/rx_valid_in   host command bytes (no backpressure)
//             tx_data_out/tx_valid_out/tx_ready_in   response byte stream
//             debug_addr_out/we/valid/type/wdata   chip8_memory debug port
//             mem_data_in          chip8_memory.data_out
//             busy_out             high whenever not waiting for a header
//             error_out            one-cycle pulse: bad header, dropped byte,
//                                  or partial-command timeout
//
//  Build option:
//             CHIP8_DEBUG_TIMEOUT_EN  when defined, a partial command idle for
//             TIMEOUT_CYCLES cycles is discarded with an error pulse.
//
//  Revision : 1.0  initial release
// ============================================================================
module chip8_debug_master #(
    parameter int          READ_LATENCY   = 2,
    parameter logic [7:0]  ACK_BYTE       = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [7:0]  rx_data_in,
    input  logic        rx_valid_in,
    output logic [7:0]  tx_data_out,
    output logic        tx_valid_out,
    input  logic        tx_ready_in,
    output logic [11:0] debug_addr_out,
    output logic        debug_we_out,
    output logic        debug_valid_out,
    output logic [1:0]  debug_type_out,
    output logic [7:0]  debug_wdata_out,
    input  logic [7:0]  mem_data_in,
    output logic        busy_out,
    output logic        error_out
);

    localparam logic [2:0] c_st_hdr   = 3'd0;
    localparam logic [2:0] c_st_addr  = 3'd1;
    localparam logic [2:0] c_st_data  = 3'd2;
    localparam logic [2:0] c_st_issue = 3'd3;
    localparam logic [2:0] c_st_wait  = 3'd4;
    localparam logic [2:0] c_st_resp  = 3'd5;

    // WAIT counts 0 .. READ_LATENCY-1; the last count is the capture cycle.
    localparam logic [3:0] c_lat_last = 4'(READ_LATENCY - 1);

    // State and command latches
    logic [2:0]  r_state,     w_state;
    logic        r_cmd_we,    w_cmd_we;
    logic [1:0]  r_cmd_type,  w_cmd_type;
    logic [11:0] r_cmd_addr,  w_cmd_addr;
    logic [7:0]  r_cmd_wdata, w_cmd_wdata;
    logic [3:0]  r_lat_cnt,   w_lat_cnt;

    // Registered outputs
    logic [11:0] r_dbg_addr,  w_dbg_addr;
    logic        r_dbg_we,    w_dbg_we;
    logic        r_dbg_valid, w_dbg_valid;
    logic [1:0]  r_dbg_type,  w_dbg_type;
    logic [7:0]  r_dbg_wdata, w_dbg_wdata;
    logic [7:0]  r_tx_data,   w_tx_data;
    logic        r_tx_valid;
    logic        r_busy;
    logic        r_error,     w_error;

    logic        w_timeout;

`ifdef CHIP8_DEBUG_TIMEOUT_EN
    localparam int c_TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TO_W-1:0] c_to_last = c_TO_W'(TIMEOUT_CYCLES - 1);

    logic [c_TO_W-1:0] r_to_cnt;
    logic              w_partial;

    assign w_partial = (r_state == c_st_addr) || (r_state == c_st_data);
    // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle of a partial command.
    assign w_timeout = w_partial && !rx_valid_in && (r_to_cnt == c_to_last);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_to_cnt <= '0;
        end else if (w_partial && !rx_valid_in && !w_timeout) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end else begin
            r_to_cnt <= '0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Next-state and next-output logic
    always_comb begin
        w_state     = r_state;
        w_cmd_we    = r_cmd_we;
        w_cmd_type  = r_cmd_type;
        w_cmd_addr  = r_cmd_addr;
        w_cmd_wdata = r_cmd_wdata;
        w_lat_cnt   = r_lat_cnt;
        w_tx_data   = r_tx_data;
        w_error     = 1'b0;
        w_dbg_addr  = r_dbg_addr;
        w_dbg_type  = r_dbg_type;
        w_dbg_wdata = r_dbg_wdata;
        w_dbg_we    = 1'b0;
        w_dbg_valid = 1'b0;

        case (r_state)
            c_st_hdr: begin
                if (rx_valid_in) begin
                    if (rx_data_in[4]) begin
                        w_error = 1'b1;
                    end else begin
                        w_cmd_we          = rx_data_in[7];
                        w_cmd_type        = rx_data_in[6:5];
                        w_cmd_addr[11:8]  = rx_data_in[3:0];
                        w_state           = c_st_addr;
                    end
                end
            end
            c_st_addr: begin
                if (rx_valid_in) begin
                    w_cmd_addr[7:0] = rx_data_in;
                    w_state         = r_cmd_we ? c_st_data : c_st_issue;
                end else if (w_timeout) begin
                    w_error = 1'b1;
                    w_state = c_st_hdr;
                end
            end
            c_st_data: begin
                if (rx_valid_in) begin
                    w_cmd_wdata = rx_data_in;
                    w_state     = c_st_issue;
                end else if (w_timeout) begin
                    w_error = 1'b1;
                    w_state = c_st_hdr;
                end
            end
            c_st_issue: begin
                w_error   = rx_valid_in;
                w_lat_cnt = '0;
                if (r_cmd_we) begin
                    w_tx_data = ACK_BYTE;
                    w_state   = c_st_resp;
                end else begin
                    w_state   = c_st_wait;
                end
            end
            c_st_wait: begin
                w_error = rx_valid_in;
                if (r_lat_cnt == c_lat_last) begin
                    w_tx_data = mem_data_in;
                    w_state   = c_st_resp;
                end else begin
                    w_lat_cnt = r_lat_cnt + 4'd1;
                end
            end
            c_st_resp: begin
                // A byte arriving in the accept cycle is still dropped.
                w_error = rx_valid_in;
                if (tx_ready_in) begin
                    w_state = c_st_hdr;
                end
            end
            default: begin
                w_state = c_st_hdr;
            end
        endcase

        // ISSUE always lasts one cycle, so entering it is the strobe cycle.
        // The debug bus is loaded only here so it holds the last issued
        // transaction while the next command is being parsed.
        if (w_state == c_st_issue) begin
            w_dbg_valid = 1'b1;
            w_dbg_we    = w_cmd_we;
            w_dbg_addr  = w_cmd_addr;
            w_dbg_type  = w_cmd_type;
            w_dbg_wdata = w_cmd_wdata;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state     <= c_st_hdr;
            r_cmd_we    <= 1'b0;
            r_cmd_type  <= 2'd0;
            r_cmd_addr  <= 12'd0;
            r_cmd_wdata <= 8'd0;
            r_lat_cnt   <= 4'd0;
            r_dbg_addr  <= 12'd0;
            r_dbg_we    <= 1'b0;
            r_dbg_valid <= 1'b0;
            r_dbg_type  <= 2'd0;
            r_dbg_wdata <= 8'd0;
            r_tx_data   <= 8'd0;
            r_tx_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cmd_we    <= w_cmd_we;
            r_cmd_type  <= w_cmd_type;
            r_cmd_addr  <= w_cmd_addr;
            r_cmd_wdata <= w_cmd_wdata;
            r_lat_cnt   <= w_lat_cnt;
            r_dbg_addr  <= w_dbg_addr;
            r_dbg_we    <= w_dbg_we;
            r_dbg_valid <= w_dbg_valid;
            r_dbg_type  <= w_dbg_type;
            r_dbg_wdata <= w_dbg_wdata;
            r_tx_data   <= w_tx_data;
            r_tx_valid  <= (w_state == c_st_resp);
            r_busy      <= (w_state != c_st_hdr);
            r_error     <= w_error;
        end
    end

    assign tx_data_out     = r_tx_data;
    assign tx_valid_out    = r_tx_valid;
    assign debug_addr_out  = r_dbg_addr;
    assign debug_we_out    = r_dbg_we;
    assign debug_valid_out = r_dbg_valid;
    assign debug_type_out  = r_dbg_type;
    assign debug_wdata_out = r_dbg_wdata;
    assign busy_out        = r_busy;
    assign error_out       = r_error;

endmodule
`default_nettype wire

// File: tb/tb_chip8_debug_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_chip8_debug_master
//  Purpose  : Self-checking bench for chip8_debug_master with a behavioural
//             chip8_memory debug-port model (ibm.mem prefix preloaded).
//  Revision : 1.0  initial release
// ============================================================================
module tb_chip8_debug_master;

    localparam int         RL  = 2;
    localparam logic [7:0] ACK = 8'hA5;
    localparam int         TO  = 50;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [11:0] dbg_addr;
    logic        dbg_we;
    logic        dbg_valid;
    logic [1:0]  dbg_type;
    logic [7:0]  dbg_wdata;
    logic [7:0]  mem_data;
    logic        busy;
    logic        err;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] mem    [0:4095];
    logic [7:0] shadow [0:4095];

    always #5 clk = ~clk;

    chip8_debug_master #(
        .READ_LATENCY   (RL),
        .ACK_BYTE       (ACK),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .rx_data_in      (rx_data),
        .rx_valid_in     (rx_valid),
        .tx_data_out     (tx_data),
        .tx_valid_out    (tx_valid),
        .tx_ready_in     (tx_ready),
        .debug_addr_out  (dbg_addr),
        .debug_we_out    (dbg_we),
        .debug_valid_out (dbg_valid),
        .debug_type_out  (dbg_type),
        .debug_wdata_out (dbg_wdata),
        .mem_data_in     (mem_data),
        .busy_out        (busy),
        .error_out       (err)
    );

    // Memory model: data is valid only in the cycle READ_LATENCY cycles after
    // the strobe cycle, so a mistimed capture reads the filler value.
    logic        r_pend = 1'b0;
    int          r_pcnt = 0;
    logic [11:0] r_paddr = 12'd0;
    assign mem_data = (r_pend && r_pcnt == RL) ? mem[r_paddr] : 8'hEE;

    always @(posedge clk) begin
        if (dbg_valid && dbg_we) mem[dbg_addr] <= dbg_wdata;
        if (dbg_valid && !dbg_we) begin
            r_pend  <= 1'b1;
            r_pcnt  <= 1;
            r_paddr <= dbg_addr;
        end else if (r_pend) begin
            if (r_pcnt == RL) r_pend <= 1'b0;
            else              r_pcnt <= r_pcnt + 1;
        end
    end

    // Port monitors
    int   strobe_cnt = 0;
    int   err_cnt    = 0;
    int   we_glitch  = 0;
    int   dbl_strobe = 0;
    logic prev_valid = 1'b0;
    always @(posedge clk) begin
        if (dbg_valid)              strobe_cnt <= strobe_cnt + 1;
        if (err)                    err_cnt    <= err_cnt + 1;
        if (dbg_we && !dbg_valid)   we_glitch  <= we_glitch + 1;
        if (dbg_valid && prev_valid) dbl_strobe <= dbl_strobe + 1;
        prev_valid <= dbg_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    // Cycles from now until tx_valid is seen (0 = already valid).
    task automatic wait_tx(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (tx_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
            cyc++;
        end
    endtask

    task automatic accept();
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
    endtask

    function automatic logic [34:0] out_vec();
        return {tx_data, tx_valid, dbg_addr, dbg_we, dbg_valid, dbg_type,
                dbg_wdata, busy, err};
    endfunction

    task automatic test_reset();
        total++;
        if (out_vec() !== 35'd0) begin
            bad++;
            $display("FAIL reset_in: outputs=%h required=0", out_vec());
        end
        rst_n = 1'b1;
        tick();
        tick();
        total++;
        if (out_vec() !== 35'd0) begin
            bad++;
            $display("FAIL reset_idle: outputs=%h required=0", out_vec());
        end
    endtask

    task automatic test_read();
        int cyc; bit ok; int s0; logic [7:0] exp;
        s0 = strobe_cnt;
        exp_q.push_back(shadow[12'h201]);
        send_byte(8'h02);
        send_byte(8'h01);
        total++;
        if (dbg_valid !== 1'b1 || dbg_addr !== 12'h201 || dbg_we !== 1'b0 || dbg_type !== 2'd0) begin
            bad++;
            $display("FAIL read_strobe: valid=%b addr=%h we=%b type=%0d required 1/201/0/0",
                     dbg_valid, dbg_addr, dbg_we, dbg_type);
        end
        wait_tx(cyc, ok);
        exp = exp_q.pop_front();
        total++;
        if (!ok || cyc != RL + 1) begin
            bad++;
            $display("FAIL read_latency: cycles=%0d ok=%0d required=%0d", cyc, ok, RL + 1);
        end
        total++;
        if (tx_data !== exp) begin
            bad++;
            $display("FAIL read_data: got %h required %h", tx_data, exp);
        end
        accept();
        total++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || strobe_cnt - s0 != 1) begin
            bad++;
            $display("FAIL read_done: tx_valid=%b busy=%b strobes=%0d required 0/0/1",
                     tx_valid, busy, strobe_cnt - s0);
        end
    endtask

    task automatic test_write_readback();
        int cyc; bit ok; logic [7:0] exp;
        shadow[12'h005] = 8'h3C;
        exp_q.push_back(ACK);
        send_byte(8'hA0);
        send_byte(8'h05);
        send_byte(8'h3C);
        total++;
        if (dbg_valid !== 1'b1 || dbg_addr !== 12'h005 || dbg_we !== 1'b1 ||
            dbg_type !== 2'd1 || dbg_wdata !== 8'h3C) begin
            bad++;
            $display("FAIL write_strobe: v=%b a=%h we=%b t=%0d d=%h required 1/005/1/1/3c",
                     dbg_valid, dbg_addr, dbg_we, dbg_type, dbg_wdata);
        end
        wait_tx(cyc, ok);
        exp = exp_q.pop_front();
        total++;
        if (!ok || cyc != 1 || tx_data !== exp) begin
            bad++;
            $display("FAIL write_resp: cycles=%0d data=%h required 1/%h", cyc, tx_data, exp);
        end
        accept();
        total++;
        if (dbg_addr !== 12'h005 || dbg_wdata !== 8'h3C || dbg_we !== 1'b0 || dbg_type !== 2'd1) begin
            bad++;
            $display("FAIL debug_hold: a=%h d=%h we=%b t=%0d required 005/3c/0/1",
                     dbg_addr, dbg_wdata, dbg_we, dbg_type);
        end
        exp_q.push_back(shadow[12'h005]);
        send_byte(8'h20);
        send_byte(8'h05);
        wait_tx(cyc, ok);
        exp = exp_q.pop_front();
        total++;
        if (!ok || tx_data !== exp) begin
            bad++;
            $display("FAIL readback: ok=%0d got %h required %h", ok, tx_data, exp);
        end
        accept();
    endtask

    task automatic test_backpressure();
        int cyc; bit ok; int unstable; logic [7:0] exp;
        exp_q.push_back(shadow[12'h202]);
        send_byte(8'h02);
        send_byte(8'h02);
        wait_tx(cyc, ok);
        exp = exp_q.pop_front();
        total++;
        if (!ok || tx_data !== exp) begin
            bad++;
            $display("FAIL bp_data: ok=%0d got %h required %h", ok, tx_data, exp);
        end
        unstable = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tx_valid !== 1'b1 || tx_data !== exp || busy !== 1'b1) unstable++;
        end
        total++;
        if (unstable != 0) begin
            bad++;
            $display("FAIL bp_hold: unstable cycles=%0d required 0", unstable);
        end
        accept();
        total++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: tx_valid=%b busy=%b required 0/0", tx_valid, busy);
        end
    endtask

    task automatic test_malformed();
        int cyc; bit ok; int e0; int s0; logic [7:0] exp;
        e0 = err_cnt;
        s0 = strobe_cnt;
        send_byte(8'h10);
        total++;
        if (err !== 1'b1 || busy !== 1'b0 || dbg_valid !== 1'b0) begin
            bad++;
            $display("FAIL bad_header: err=%b busy=%b valid=%b required 1/0/0", err, busy, dbg_valid);
        end
        tick();
        total++;
        if (err !== 1'b0 || err_cnt - e0 != 1 || strobe_cnt != s0) begin
            bad++;
            $display("FAIL bad_header_pulse: err=%b pulses=%0d strobes=%0d required 0/1/0",
                     err, err_cnt - e0, strobe_cnt - s0);
        end
        // Stray byte while waiting for read data.
        exp_q.push_back(shadow[12'h203]);
        send_byte(8'h02);
        send_byte(8'h03);
        tick();
        send_byte(8'hFF);
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL drop_in_wait: err=%b required 1", err);
        end
        wait_tx(cyc, ok);
        exp = exp_q.pop_front();
        total++;
        if (!ok || tx_data !== exp) begin
            bad++;
            $display("FAIL drop_wait_data: ok=%0d got %h required %h", ok, tx_data, exp);
        end
        // Byte arriving in the same cycle the response is accepted.
        rx_data  = 8'h02;
        rx_valid = 1'b1;
        tx_ready = 1'b1;
        tick();
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        total++;
        if (err !== 1'b1 || busy !== 1'b0 || tx_valid !== 1'b0) begin
            bad++;
            $display("FAIL accept_collision: err=%b busy=%b tx_valid=%b required 1/0/0",
                     err, busy, tx_valid);
        end
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL collision_dropped: busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int cyc; bit ok; int s0; logic [7:0] exp;
        send_byte(8'h02);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_vec() !== 35'd0) begin
            bad++;
            $display("FAIL reset_mid_cmd: outputs=%h required=0", out_vec());
        end
        tick();
        rst_n = 1'b1;
        s0 = strobe_cnt;
        repeat (5) tick();
        total++;
        if (strobe_cnt != s0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_discard: strobes=%0d busy=%b required 0/0", strobe_cnt - s0, busy);
        end
        exp_q.push_back(shadow[12'h200]);
        send_byte(8'h02);
        send_byte(8'h00);
        wait_tx(cyc, ok);
        exp = exp_q.pop_front();
        total++;
        if (!ok || cyc != RL + 1 || tx_data !== exp) begin
            bad++;
            $display("FAIL reset_clean_read: cycles=%0d got %h required %0d/%h", cyc, tx_data, RL + 1, exp);
        end
        // Reset while a response is pending.
        rst_n = 1'b0;
        #1;
        total++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_resp: tx_valid=%b data=%h busy=%b required 0/00/0",
                     tx_valid, tx_data, busy);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_timeout();
        int e0; int s0; int first; int cyc; bit ok; logic [7:0] exp;
        e0 = err_cnt;
        s0 = strobe_cnt;
        first = -1;
        send_byte(8'h02);
`ifdef CHIP8_DEBUG_TIMEOUT_EN
        for (int k = 1; k <= TO + 20; k++) begin
            tick();
            if (err === 1'b1 && first < 0) first = k;
        end
        total++;
        if (first != TO || busy !== 1'b0 || strobe_cnt != s0 || err_cnt - e0 != 1) begin
            bad++;
            $display("FAIL timeout: at=%0d busy=%b strobes=%0d pulses=%0d required %0d/0/0/1",
                     first, busy, strobe_cnt - s0, err_cnt - e0, TO);
        end
`else
        for (int k = 1; k <= TO + 50; k++) begin
            tick();
            if (err === 1'b1 && first < 0) first = k;
        end
        total++;
        if (first != -1 || busy !== 1'b1 || strobe_cnt != s0) begin
            bad++;
            $display("FAIL no_timeout: err_at=%0d busy=%b strobes=%0d required -1/1/0",
                     first, busy, strobe_cnt - s0);
        end
        exp_q.push_back(shadow[12'h201]);
        send_byte(8'h01);
        wait_tx(cyc, ok);
        exp = exp_q.pop_front();
        total++;
        if (!ok || tx_data !== exp) begin
            bad++;
            $display("FAIL late_complete: ok=%0d got %h required %h", ok, tx_data, exp);
        end
        accept();
`endif
    endtask

    task automatic test_back_to_back();
        int cyc; bit ok; logic [11:0] a; logic [7:0] d; logic [1:0] t; logic [7:0] exp;
        int errs;
        errs = 0;
        for (int i = 0; i < 6; i++) begin
            a = 12'h300 + 12'(i * 37);
            d = 8'($urandom_range(0, 255));
            t = 2'(i);
            shadow[a] = d;
            exp_q.push_back(ACK);
            send_byte({1'b1, t, 1'b0, a[11:8]});
            send_byte(a[7:0]);
            send_byte(d);
            if (dbg_valid !== 1'b1 || dbg_addr !== a || dbg_type !== t || dbg_wdata !== d) errs++;
            wait_tx(cyc, ok);
            exp = exp_q.pop_front();
            if (!ok || tx_data !== exp) errs++;
            accept();
            exp_q.push_back(shadow[a]);
            send_byte({1'b0, t, 1'b0, a[11:8]});
            send_byte(a[7:0]);
            wait_tx(cyc, ok);
            exp = exp_q.pop_front();
            total++;
            if (!ok || tx_data !== exp) begin
                bad++;
                $display("FAIL b2b_read[%0d]: addr=%h got %h required %h", i, a, tx_data, exp);
            end
            accept();
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL b2b_write: bad write cycles=%0d required 0", errs);
        end
    endtask

    task automatic test_invariants();
        total++;
        if (we_glitch != 0 || dbl_strobe != 0) begin
            bad++;
            $display("FAIL strobe_shape: we_without_valid=%0d long_strobes=%0d required 0/0",
                     we_glitch, dbl_strobe);
        end
    endtask

    initial begin
        logic [7:0] ibm [0:15];
        ibm = '{8'h00, 8'hE0, 8'hA2, 8'h2A, 8'h60, 8'h0C, 8'h61, 8'h08,
                8'hD0, 8'h1F, 8'h70, 8'h09, 8'hA2, 8'h39, 8'hD0, 8'h1F};
        for (int i = 0; i < 4096; i++) begin
            mem[i]    = 8'h00;
            shadow[i] = 8'h00;
        end
        for (int i = 0; i < 16; i++) begin
            mem[12'h200 + i]    = ibm[i];
            shadow[12'h200 + i] = ibm[i];
        end
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_read();
        test_write_readback();
        test_backpressure();
        test_malformed();
        test_reset_mid();
        test_timeout();
        test_back_to_back();
        test_invariants();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
